inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//   Inverse of the instruction decoder. Takes decoded instruction fields (opcode, funct3, funct7,
//   rs1, rs2, rd, imm) over a valid/ready stream and builds the 32-bit RV instruction word.
//   Each legal word leaves through a registered output with its instruction-memory address, so
//   the block can fill instruction memory (self-test/boot program builder).
//   Round-trip contract: decoder(inst_encoder(fields)) returns the same fields.
// PARAMETERS
//   XLEN       32   width of imm and out_addr (32 or 64)
//   DEPTH      1024 max words emitted before FULL; >=1
//   BASE_ADDR  0    address of first emitted word; word-aligned
// PORTS
//   clock      in   1          single clock, rising edge
//   reset      in   1          synchronous, active-high
//   clear      in   1          sync restart: count->0, drops pending output
//   in_valid   in   1          field bundle valid
//   in_ready   out  1          block can accept bundle this cycle
//   opcode     in   7          inst[6:0]
//   funct3     in   3          inst[14:12] (ignored for U/J)
//   funct7     in   7          inst[31:25] (R-type only)
//   rs1,rs2,rd in   5 each     register fields (used per itype)
//   imm        in   XLEN       sign-extended immediate, decoder format
//   out_valid  out  1          out_inst/out_addr valid
//   out_ready  in   1          sink accepts output
//   out_inst   out  32         encoded instruction
//   out_addr   out  XLEN       BASE_ADDR + 4*index of this word
//   err        out  1          1-cycle pulse: accepted bundle was illegal and dropped
//   count      out  clog2(DEPTH+1)  legal words accepted since reset/clear
//   done       out  1          high in FULL state
// BEHAVIOUR
//   Reset: out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, count=0, done=0, state RUN.
//   itype from opcode, same as decoder: U=LUI/AUIPC, J=JAL, B=BRANCH, S=STORE, R=OP/OP_32,
//     I=LOAD/OP_IMM/OP_IMM_32/JALR/MISC_MEM/SYSTEM; any other opcode is illegal.
//   Encoding:
//     R {funct7,rs2,rs1,funct3,rd,op}
//     I {imm[11:0],rs1,funct3,rd,op}; shift funct7 bits come from imm[11:6], as decoded
//     S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
//     B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}
//     U {imm[31:12],rd,op}
//     J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   Legality: I/S imm == sext(imm[11:0]).
//     B imm == sext(imm[12:0]) and imm[0]==0.
//     J imm == sext(imm[20:0]) and imm[0]==0.
//     U imm[11:0]==0 and imm == sext(imm[31:0]).
//   in_ready = !reset && !clear && state==RUN && (!out_valid || out_ready).
//   Accept = in_valid && in_ready. Latency 1: out_* registered on the accept edge.
//   Legal accept: out_valid<=1, out_addr<=BASE_ADDR+4*count, count<=count+1.
//   Illegal accept: bundle consumed, err<=1 for one cycle, no output, count unchanged.
//     out_valid<=0 unless the held word is still stalled.
//   Output handshake: out_valid && out_ready retires the word. While stalled, out_inst and
//     out_addr stay stable; out_valid is never dropped except by reset/clear.
//   Retire with no new accept: out_valid<=0.
//   FSM RUN->FULL when a legal accept makes count==DEPTH; done=1, in_ready=0.
//     The last word still drains normally.
//   FULL->RUN only on clear or reset.
//   clear (any state): count<=0, out_valid<=0, err<=0, state RUN; same-cycle input not accepted.
//   out_addr arithmetic mod 2^XLEN.
// TESTING
//   ADDI op=0010011 f3=0 rd=1 rs1=0 imm=5 -> out_inst=0x00500093, out_addr=0, count=1 next cycle.
//   ADD op=0110011 f7=0 f3=0 rd=3 rs1=1 rs2=2 -> 0x002081B3, out_addr=4.
//   BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; LUI rd=5 imm=0x12345000 -> 0x123452B7.
//   BEQ imm=3 / ADDI imm=4096 / opcode=0000000 -> err pulse, out_valid=0, count unchanged.
//   out_ready=0 for 3 cycles after a word -> in_ready=0, out_inst/out_addr stable; resumes on ready.
//   DEPTH=4, push 5 legal bundles with out_ready=1:
//     addrs 0,4,8,0xC; done=1, in_ready=0; 5th held.
//     clear -> count=0, next word at addr 0.
//   Random legal bundles -> decoder of out_inst reproduces all fields (round-trip scoreboard).

Source files
------------

// File: rtl/inst_encoder.sv
// Purpose : builds 32-bit RV instruction words from decoded field bundles and emits them
//           with sequential instruction-memory addresses (boot / self-test program builder).
// Latency : 1 cycle, accept edge -> registered out_inst/out_addr/out_valid, err pulse.
// Backpressure: in_ready drops while an output word is stalled (out_valid && !out_ready),
//           while FULL, and during reset/clear.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   clear               synchronous restart: count->0, pending output dropped, state RUN
//   in_valid/in_ready   field bundle handshake (opcode, funct3, funct7, rs1, rs2, rd, imm)
//   out_valid/out_ready output word handshake (out_inst, out_addr)
//   err                 1-cycle pulse when an accepted bundle was illegal and dropped
//   count               legal words accepted since reset/clear
//   done                high while FULL (DEPTH words accepted)

module inst_encoder #(
  parameter int unsigned         XLEN      = 32,
  parameter int unsigned         DEPTH     = 1024,
  parameter logic [XLEN-1:0]     BASE_ADDR = '0,
  localparam int unsigned        CW        = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_addr,
  output logic            err,
  output logic [CW-1:0]   count,
  output logic            done
);

  // Base opcodes recognised by the matching decoder.
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IT_R, IT_I, IT_S, IT_B, IT_U, IT_J, IT_BAD
  } itype_e;

  typedef enum logic {
    S_RUN,
    S_FULL
  } state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_inst_q, out_inst_d;
  logic [XLEN-1:0]    out_addr_q, out_addr_d;
  logic               err_q, err_d;
  logic [CW-1:0]      count_q, count_d;

  itype_e             itype;
  logic [31:0]        word;
  logic               legal;
  logic               accept;
  logic [CW-1:0]      count_inc;

  // ------------------------------------------------------------------
  // Instruction format from opcode.
  // ------------------------------------------------------------------
  always_comb begin
    itype = IT_BAD;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC:               itype = IT_U;
      OPC_JAL:                          itype = IT_J;
      OPC_BRANCH:                       itype = IT_B;
      OPC_STORE:                        itype = IT_S;
      OPC_OP, OPC_OP_32:                itype = IT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: itype = IT_I;
      default:                          itype = IT_BAD;
    endcase
  end

  // ------------------------------------------------------------------
  // Word assembly. Shift-immediate funct7 bits ride in imm[11:6], so the
  // plain I-format packing already places them where the decoder looks.
  // ------------------------------------------------------------------
  always_comb begin
    word = 32'h0;
    unique case (itype)
      IT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      IT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      IT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IT_U: word = {imm[31:12], rd, opcode};
      IT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = 32'h0;
    endcase
  end

  // ------------------------------------------------------------------
  // Legality: the immediate must be exactly representable in the target
  // field, otherwise decoding the word would not return the same imm.
  // ------------------------------------------------------------------
  always_comb begin
    legal = 1'b0;
    unique case (itype)
      IT_R: legal = 1'b1;
      IT_I,
      IT_S: legal = (imm == XLEN'($signed(imm[11:0])));
      IT_B: legal = (imm == XLEN'($signed(imm[12:0]))) && !imm[0];
      IT_J: legal = (imm == XLEN'($signed(imm[20:0]))) && !imm[0];
      IT_U: legal = (imm[11:0] == 12'h0) && (imm == XLEN'($signed(imm[31:0])));
      default: legal = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // Handshake. A new bundle is only taken when the output slot is free
  // or retiring this very cycle, so a stalled word is never overwritten.
  // ------------------------------------------------------------------
  assign in_ready  = !reset && !clear && (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + CW'(1);

  // ------------------------------------------------------------------
  // Next-state / datapath.
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    err_d       = 1'b0;
    count_d     = count_q;

    if (clear) begin
      // out_inst/out_addr keep their last value; out_valid=0 marks them stale.
      state_d     = S_RUN;
      out_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      if (accept && legal) begin
        out_valid_d = 1'b1;
        out_inst_d  = word;
        out_addr_d  = BASE_ADDR + (XLEN'(count_q) << 2);
        count_d     = count_inc;
        if (count_inc == CW'(DEPTH)) begin
          state_d = S_FULL;
        end
      end else if (out_valid_q && out_ready) begin
        // Covers both a plain retire and an illegal accept: an illegal
        // accept implies the held word (if any) is retiring this cycle.
        out_valid_d = 1'b0;
      end

      if (accept && !legal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign count     = count_q;
  assign done      = (state_q == S_FULL);

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic        in_ready, out_valid, err, done;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, out_inst, out_addr;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total    = 0;

  inst_encoder #(.XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .count(count), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                            input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = d; imm = im;
  endtask

  // One-cycle bundle presentation; caller guarantees in_ready is high.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic [31:0] im);
    set_fields(op, f3, f7, r1, r2, d, im);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Reference decoder: 0=R 1=I 2=S 3=B 4=U 5=J 6=illegal
  function automatic int fmt(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111: return 4;
      7'b1101111:             return 5;
      7'b1100011:             return 3;
      7'b0100011:             return 2;
      7'b0110011, 7'b0111011: return 0;
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b0001111, 7'b1110011: return 1;
      default:                return 6;
    endcase
  endfunction

  // Field vector {op,f3,f7,rs1,rs2,rd,imm} with fields unused by the format zeroed.
  function automatic logic [63:0] masked(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] d,
                                         input logic [31:0] im);
    case (fmt(op))
      0: return {op, f3, f7, r1, r2, d, 32'h0};
      1: return {op, f3, 7'h0, r1, 5'h0, d, im};
      2, 3: return {op, f3, 7'h0, r1, r2, 5'h0, im};
      default: return {op, 3'h0, 7'h0, 5'h0, 5'h0, d, im};
    endcase
  endfunction

  function automatic logic [63:0] decode(input logic [31:0] w);
    logic [31:0] im;
    im = 32'h0;
    case (fmt(w[6:0]))
      1: im = 32'($signed(w[31:20]));
      2: im = 32'($signed({w[31:25], w[11:7]}));
      3: im = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      4: im = {w[31:12], 12'h0};
      5: im = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: im = 32'h0;
    endcase
    return masked(w[6:0], w[14:12], w[31:25], w[19:15], w[24:20], w[11:7], im);
  endfunction

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 32'h0);
    step(); step();
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_inst, out_addr, err, count, done} !== {1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0})
      $display("FAIL reset_state: vld=%b inst=%h addr=%h err=%b cnt=%0d done=%b want all zero",
               out_valid, out_inst, out_addr, err, count, done);
    else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_encode();
    send(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    total++;
    if ({out_valid, out_inst, out_addr, count} !== {1'b1, 32'h00500093, 32'h0, 3'd1})
      $display("FAIL addi: vld=%b inst=%h addr=%h cnt=%0d want 1 00500093 0 1", out_valid, out_inst, out_addr, count);
    else pass_cnt++;
    send(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    total++;
    if ({out_inst, out_addr, count} !== {32'h002081B3, 32'h4, 3'd2})
      $display("FAIL add: inst=%h addr=%h cnt=%0d want 002081b3 4 2", out_inst, out_addr, count);
    else pass_cnt++;
    send(7'b1100011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, -32'sd8);
    total++;
    if ({out_inst, out_addr} !== {32'hFE208CE3, 32'h8})
      $display("FAIL beq: inst=%h addr=%h want fe208ce3 8", out_inst, out_addr);
    else pass_cnt++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL retire_idle: vld=%b want 0", out_valid); else pass_cnt++;
    do_clear();
    send(7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    total++;
    if ({out_inst, out_addr, count} !== {32'h123452B7, 32'h0, 3'd1})
      $display("FAIL lui: inst=%h addr=%h cnt=%0d want 123452b7 0 1", out_inst, out_addr, count);
    else pass_cnt++;
    step();
    do_clear();
  endtask

  task automatic test_illegal();
    logic [6:0]  ops [3] = '{7'b1100011, 7'b0010011, 7'b0000000};
    logic [31:0] ims [3] = '{32'd3, 32'd4096, 32'd0};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, ims[i]);
      total++;
      if ({err, out_valid, count} !== {1'b1, 1'b0, 3'd0})
        $display("FAIL illegal_%0d: err=%b vld=%b cnt=%0d want 1 0 0", i, err, out_valid, count);
      else pass_cnt++;
      step();
      total++; if (err !== 1'b0) $display("FAIL err_pulse_%0d: err=%b want 0", i, err); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    set_fields(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({in_ready, out_valid, out_inst, out_addr} !== {1'b0, 1'b1, 32'h00500093, 32'h0})
        $display("FAIL stall_%0d: rdy=%b vld=%b inst=%h addr=%h want 0 1 00500093 0",
                 c, in_ready, out_valid, out_inst, out_addr);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release_rdy: got %b want 1", in_ready); else pass_cnt++;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_inst, out_addr, count} !== {1'b1, 32'h002081B3, 32'h4, 3'd2})
      $display("FAIL stall_resume: vld=%b inst=%h addr=%h cnt=%0d want 1 002081b3 4 2",
               out_valid, out_inst, out_addr, count);
    else pass_cnt++;
    step();
    do_clear();
  endtask

  task automatic test_full();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'(i + 1), 32'(i));
      total++;
      if ({out_valid, out_addr} !== {1'b1, 32'(4 * i)})
        $display("FAIL full_addr_%0d: vld=%b addr=%h want 1 %h", i, out_valid, out_addr, 32'(4 * i));
      else pass_cnt++;
    end
    total++;
    if ({done, in_ready, count} !== {1'b1, 1'b0, 3'd4})
      $display("FAIL full_state: done=%b rdy=%b cnt=%0d want 1 0 4", done, in_ready, count);
    else pass_cnt++;
    set_fields(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 32'd9);
    in_valid = 1'b1;
    step();
    total++;
    if ({out_valid, count, done, in_ready} !== {1'b0, 3'd4, 1'b1, 1'b0})
      $display("FAIL full_hold: vld=%b cnt=%0d done=%b rdy=%b want 0 4 1 0", out_valid, count, done, in_ready);
    else pass_cnt++;
    clear = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL clear_blocks_in: rdy=%b want 0", in_ready); else pass_cnt++;
    step();
    clear = 1'b0;
    total++;
    if ({count, done, out_valid} !== {3'd0, 1'b0, 1'b0})
      $display("FAIL clear_state: cnt=%0d done=%b vld=%b want 0 0 0", count, done, out_valid);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_addr, count, out_inst} !== {1'b1, 32'h0, 3'd1, 32'h00900493})
      $display("FAIL after_clear: vld=%b addr=%h cnt=%0d inst=%h want 1 0 1 00900493",
               out_valid, out_addr, count, out_inst);
    else pass_cnt++;
    step();
    do_clear();
  endtask

  task automatic test_roundtrip();
    logic [6:0]  opl [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011,
                              7'b0111011, 7'b0001111, 7'b1110011};
    logic [6:0]  op;
    logic [31:0] r, im;
    logic [63:0] want, got;
    int n = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      op = opl[$urandom_range(12)];
      r  = $urandom;
      case (fmt(op))
        1, 2: im = 32'($signed(r[11:0]));
        3:    im = 32'($signed({r[12:1], 1'b0}));
        4:    im = {r[31:12], 12'h0};
        5:    im = 32'($signed({r[20:1], 1'b0}));
        default: im = r;
      endcase
      r = $urandom;
      send(op, r[2:0], r[9:3], r[14:10], r[19:15], r[24:20], im);
      want = masked(op, r[2:0], r[9:3], r[14:10], r[19:15], r[24:20], im);
      got  = decode(out_inst);
      total++;
      if (got !== want || out_valid !== 1'b1)
        $display("FAIL roundtrip_%0d: vld=%b inst=%h fields=%h want %h", k, out_valid, out_inst, got, want);
      else pass_cnt++;
      n++;
      if (n == DEPTH) begin
        n = 0;
        do_clear();
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_illegal();
    test_stall();
    test_full();
    test_roundtrip();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
